ro_result_packer: RTL and testbench
===================================

// Module: ro_result_packer
// PURPOSE
// - Drains the RO result FIFO (show-ahead: rd_data is the head word whenever !empty; rd_en pops it).
// - Packs each 20-bit sample zero-extended into 32-bit lanes, LANES lanes per LINE_WIDTH output word.
// - Output words go to the host write path over a valid/ready handshake.
// - flush forces out a partial word at the end of a capture run, tagged last.
// PARAMETERS
// - SAMPLE_WIDTH  20   width of fifo_rd_data; must be <= LANE_WIDTH
// - LANE_WIDTH    32   width of one lane in the output word
// - LINE_WIDTH    512  output word width; LANES = LINE_WIDTH/LANE_WIDTH (16)
// - COUNT_WIDTH   32   width of the total_words counter
// PORTS
// - clk           in   1                  clock
// - rst           in   1                  asynchronous reset, active-high
// - flush         in   1                  one-cycle pulse: emit the current partial word and mark it last
// - fifo_empty    in   1                  result FIFO empty
// - fifo_rd_data  in   SAMPLE_WIDTH       head-of-FIFO sample (show-ahead)
// - fifo_rd_en    out  1                  pop head sample this cycle
// - out_valid     out  1                  out_data/out_count/out_last valid
// - out_ready     in   1                  downstream accepts the word when out_valid && out_ready
// - out_data      out  LINE_WIDTH         packed word; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH], unused lanes 0
// - out_count     out  $clog2(LANES)+1    number of valid lanes (1..LANES)
// - out_last      out  1                  word was closed by flush
// - total_words   out  COUNT_WIDTH        words accepted downstream since reset (wraps)
// BEHAVIOUR
// - Reset: state FILL, lane_idx=0, line reg=0, flush_pend=0, and every output 0 (fifo_rd_en, out_valid, out_data, out_count, out_last, total_words).
// - fifo_rd_en = (state==FILL) && !fifo_empty. It is combinational and never asserts while empty or in EMIT.
// - FILL, on a pop:
//   - lane[lane_idx] <= zero-extended fifo_rd_data, then lane_idx++.
//   - If this was the lane LANES-1 pop: go to EMIT with count=LANES, last=0.
// - FILL, flush with lane_idx>0: go to EMIT with count=lane_idx (plus 1 if a pop happens in the same cycle) and last=1.
// - FILL, flush with lane_idx==0 and no pop: no word is emitted and the flush is dropped.
// - Flush and a pop on the same cycle: the popped sample goes into the word first, then the word closes as last.
// - Flush on the same cycle as the pop that fills the lane LANES-1 word: the full word is emitted with last=1.
// - EMIT: out_valid=1, and out_data/out_count/out_last hold stable until out_ready.
// - On accept: total_words++ (modulo 2^COUNT_WIDTH), the line is cleared to 0, lane_idx=0, and the state returns to FILL.
//   - Earliest next pop is the cycle after accept, so 1 bubble per word.
// - Flush arriving during EMIT: set flush_pend.
//   - If the word in EMIT is accepted and the next FILL has lane_idx>0, that word closes as last.
//   - flush_pend clears when a last word is accepted, or on the first FILL cycle when lane_idx==0.
// - Latency: last lane popped at cycle t gives out_valid=1 at t+1.
// - rst mid-word: the partial data is discarded and out_valid drops immediately (async).
// - The FIFO is never popped when the block cannot store the sample, so no sample is lost or duplicated.
// STRUCTURE
// - ro_pkg holds:
//   - typedef enum logic {PK_FILL, PK_EMIT} packer_state_t
//   - localparams RO_SAMPLE_WIDTH=20, RO_LANE_WIDTH=32, RO_LINE_WIDTH=512
// - Single module. The FSM and lane write-enable decode are inline; no sub-module is needed.
// - Lane storage is LANES registers with per-lane write enables decoded from lane_idx.
// TESTING
// - 16 samples 1..16 pushed, out_ready=1 -> one word, lanes 0..15 = 1..16, count=16, last=0, total_words=1.
// - 5 samples 0xFFFFF then flush -> count=5, last=1, lanes 0-4 = 0x000FFFFF, lanes 5-15 = 0.
// - 16 samples with out_ready=0 for 10 cycles -> out_data stable, fifo_rd_en=0 throughout, word accepted on the out_ready cycle.
// - Flush on the same cycle as the 3rd pop -> count=3, last=1; flush with an empty line -> no out_valid.
// - Flush during EMIT of a full word, then 2 samples -> second word count=2, last=1.
// - rst asserted with 7 lanes filled -> out_valid=0, total_words=0; next 16 samples form a clean word.

Source files
------------

// File: rtl/ro_pkg.sv
// Shared types and default widths for the RO result packing path.
package ro_pkg;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_EMIT = 1'b1
  } packer_state_t;

  localparam int RO_SAMPLE_WIDTH = 20;
  localparam int RO_LANE_WIDTH   = 32;
  localparam int RO_LINE_WIDTH   = 512;
  localparam int RO_COUNT_WIDTH  = 32;

endpackage

// File: rtl/ro_result_packer.sv
// Drains the show-ahead RO result FIFO into LANES-wide output words.
// Output words leave over valid/ready; a flush closes a partial word as last.
module ro_result_packer
  import ro_pkg::*;
#(
  parameter int  SAMPLE_WIDTH = RO_SAMPLE_WIDTH,
  parameter int  LANE_WIDTH   = RO_LANE_WIDTH,
  parameter int  LINE_WIDTH   = RO_LINE_WIDTH,
  parameter int  COUNT_WIDTH  = RO_COUNT_WIDTH,
  localparam int LANES        = LINE_WIDTH / LANE_WIDTH,
  localparam int CW           = $clog2(LANES) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fifo_empty,
  input  logic [SAMPLE_WIDTH-1:0] fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LINE_WIDTH-1:0]   out_data,
  output logic [CW-1:0]           out_count,
  output logic                    out_last,
  output logic [COUNT_WIDTH-1:0]  total_words
);

  localparam logic [CW-1:0] LAST_IDX = CW'(LANES - 1);

  packer_state_t          r_state;
  packer_state_t          w_state_nxt;
  logic [CW-1:0]          r_lane_idx;
  logic [CW-1:0]          w_lane_idx_nxt;
  logic                   r_flush_pend;
  logic                   w_flush_pend_nxt;
  logic [CW-1:0]          r_out_count;
  logic [CW-1:0]          w_out_count_nxt;
  logic                   r_out_last;
  logic                   w_out_last_nxt;
  logic [COUNT_WIDTH-1:0] r_total_words;
  logic [COUNT_WIDTH-1:0] w_total_words_nxt;

  logic                   w_pop;
  logic                   w_accept;
  logic                   w_flush_req;
  logic [LANE_WIDTH-1:0]  w_sample_ext;
  logic [LANES-1:0]       w_lane_we;

  assign w_pop        = (r_state == PK_FILL) && !fifo_empty;
  assign w_accept     = (r_state == PK_EMIT) && out_ready;
  assign w_sample_ext = LANE_WIDTH'(fifo_rd_data);
  // A flush parked during EMIT only acts once the new word holds at least one lane.
  assign w_flush_req  = flush || (r_flush_pend && (r_lane_idx != '0));

  assign fifo_rd_en  = w_pop;
  assign out_valid   = (r_state == PK_EMIT);
  assign out_count   = r_out_count;
  assign out_last    = r_out_last;
  assign total_words = r_total_words;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_WIDTH-1:0] r_lane;

    assign w_lane_we[gi] = w_pop && (r_lane_idx == CW'(gi));

    // Lane storage: written on its pop, cleared when the word is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lane <= '0;
      end else if (w_accept) begin
        r_lane <= '0;
      end else if (w_lane_we[gi]) begin
        r_lane <= w_sample_ext;
      end else begin
        r_lane <= r_lane;
      end
    end

    assign out_data[gi*LANE_WIDTH +: LANE_WIDTH] = r_lane;
  end

  // Next-state decode for the fill/emit FSM and the word descriptor.
  always_comb begin
    w_state_nxt       = r_state;
    w_lane_idx_nxt    = r_lane_idx;
    w_flush_pend_nxt  = r_flush_pend;
    w_out_count_nxt   = r_out_count;
    w_out_last_nxt    = r_out_last;
    w_total_words_nxt = r_total_words;
    case (r_state)
      PK_FILL: begin
        if (w_pop) begin
          w_lane_idx_nxt = r_lane_idx + CW'(1);
          if ((r_lane_idx == LAST_IDX) || w_flush_req) begin
            w_state_nxt     = PK_EMIT;
            w_out_count_nxt = r_lane_idx + CW'(1);
            w_out_last_nxt  = w_flush_req;
            if (w_flush_req) begin
              w_flush_pend_nxt = 1'b0;
            end else begin
              w_flush_pend_nxt = r_flush_pend;
            end
          end else begin
            w_state_nxt = PK_FILL;
          end
        end else if (w_flush_req && (r_lane_idx != '0)) begin
          w_state_nxt      = PK_EMIT;
          w_out_count_nxt  = r_lane_idx;
          w_out_last_nxt   = 1'b1;
          w_flush_pend_nxt = 1'b0;
        end else if (r_lane_idx == '0) begin
          // Nothing to close: a flush on an empty line is dropped.
          w_flush_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = PK_FILL;
        end
      end
      PK_EMIT: begin
        if (flush) begin
          w_flush_pend_nxt = 1'b1;
        end else begin
          w_flush_pend_nxt = r_flush_pend;
        end
        if (w_accept) begin
          w_state_nxt       = PK_FILL;
          w_lane_idx_nxt    = '0;
          w_out_count_nxt   = '0;
          w_out_last_nxt    = 1'b0;
          w_total_words_nxt = r_total_words + COUNT_WIDTH'(1);
          if (r_out_last && !flush) begin
            w_flush_pend_nxt = 1'b0;
          end else begin
            w_flush_pend_nxt = flush || r_flush_pend;
          end
        end else begin
          w_state_nxt = PK_EMIT;
        end
      end
      default: begin
        w_state_nxt      = PK_FILL;
        w_lane_idx_nxt   = '0;
        w_flush_pend_nxt = 1'b0;
        w_out_count_nxt  = '0;
        w_out_last_nxt   = 1'b0;
      end
    endcase
  end

  // State and descriptor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= PK_FILL;
      r_lane_idx    <= '0;
      r_flush_pend  <= 1'b0;
      r_out_count   <= '0;
      r_out_last    <= 1'b0;
      r_total_words <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lane_idx    <= w_lane_idx_nxt;
      r_flush_pend  <= w_flush_pend_nxt;
      r_out_count   <= w_out_count_nxt;
      r_out_last    <= w_out_last_nxt;
      r_total_words <= w_total_words_nxt;
    end
  end

endmodule

// File: tb/tb_ro_result_packer.sv
// Self-checking bench for ro_result_packer: vector table, corner sequences,
// and a randomized run against a word-grouping reference model.
module tb_ro_result_packer;

  localparam int SW    = 20;
  localparam int LW    = 32;
  localparam int LINEW = 512;
  localparam int CNTW  = 5;
  localparam int TW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             fifo_empty;
  logic [SW-1:0]    fifo_rd_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [LINEW-1:0] out_data;
  logic [CNTW-1:0]  out_count;
  logic             out_last;
  logic [TW-1:0]    total_words;

  always #5 clk = ~clk;

  ro_result_packer dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_last(out_last), .total_words(total_words)
  );

  typedef struct {
    int            n;
    bit            mode;       // 0: base+k, 1: constant base
    logic [SW-1:0] base;
    int            flush_at;   // 0 none, k>0 with k-th pop, -1 after all popped
    int            exp_count;
    bit            exp_last;
  } vec_t;

  vec_t             vecs[6];
  logic [SW-1:0]    fq[$];
  logic [SW-1:0]    src[$];
  logic [LINEW-1:0] obs_data[$];
  int               obs_count[$];
  bit               obs_last[$];
  int               n_cmp;
  int               n_bad;
  int               exp_total;

  task automatic chk(input string name, input logic [LINEW-1:0] act, input logic [LINEW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fq.size() == 0) begin
      fifo_empty   = 1'b1;
      fifo_rd_data = '0;
    end else begin
      fifo_empty   = 1'b0;
      fifo_rd_data = fq[0];
    end
  endtask

  task automatic tick();
    bit            p;
    logic [SW-1:0] tmp;
    drive_fifo();
    #1;
    p = fifo_rd_en;
    chk("rd_en_guard", LINEW'(fifo_rd_en & (fifo_empty | out_valid)), '0);
    if (out_valid && out_ready) begin
      obs_data.push_back(out_data);
      obs_count.push_back(int'(out_count));
      obs_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
    if (p) tmp = fq.pop_front();
    flush = 1'b0;
    drive_fifo();
  endtask

  function automatic logic [LINEW-1:0] pack(input int start, input int cnt);
    logic [LINEW-1:0] d;
    d = '0;
    for (int i = 0; i < cnt; i++) d[i*LW +: LW] = LW'(src[start+i]);
    return d;
  endfunction

  task automatic check_word(input string tag, input int idx, input int start, input int cnt, input bit last);
    if (obs_data.size() <= idx) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_present: got %0d words, required more than %0d", tag, obs_data.size(), idx);
    end else begin
      chk($sformatf("%s_data", tag), obs_data[idx], pack(start, cnt));
      chk($sformatf("%s_count", tag), LINEW'(obs_count[idx]), LINEW'(cnt));
      chk($sformatf("%s_last", tag), LINEW'(obs_last[idx]), LINEW'(last));
    end
  endtask

  task automatic run_until(input int nwords, input int budget, input string tag);
    int c;
    c = 0;
    while (obs_data.size() < nwords && c < budget) begin
      tick();
      c++;
    end
    if (obs_data.size() < nwords) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d words, required %0d", tag, obs_data.size(), nwords);
    end
  endtask

  task automatic push_n(input int n, input bit mode, input logic [SW-1:0] base);
    logic [SW-1:0] v;
    for (int k = 0; k < n; k++) begin
      v = mode ? base : base + SW'(k);
      src.push_back(v);
      fq.push_back(v);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_count.delete();
    obs_last.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            popped;
    int            c;
    int            n;
    int            pushed;
    int            nfull;
    bit            flushed;
    bit            p16;
    bit            pv;
    bit            pr;
    logic [LINEW-1:0] pd;
    logic [LINEW-1:0] d0;
    logic [31:0]   rv;

    n_cmp = 0; n_bad = 0; exp_total = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;

    vecs[0] = '{16, 1'b0, 20'h00001,  0, 16, 1'b0};
    vecs[1] = '{ 5, 1'b1, 20'hFFFFF, -1,  5, 1'b1};
    vecs[2] = '{ 3, 1'b0, 20'h00100,  3,  3, 1'b1};
    vecs[3] = '{16, 1'b0, 20'h00200, 16, 16, 1'b1};
    vecs[4] = '{ 1, 1'b0, 20'h00007,  1,  1, 1'b1};
    vecs[5] = '{15, 1'b0, 20'hFFFF0, -1, 15, 1'b1};

    #12;
    chk("reset_valid", LINEW'(out_valid), '0);
    chk("reset_data", out_data, '0);
    chk("reset_count", LINEW'(out_count), '0);
    chk("reset_last", LINEW'(out_last), '0);
    chk("reset_total", LINEW'(total_words), '0);
    chk("reset_rd_en", LINEW'(fifo_rd_en), '0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      src.delete();
      clear_obs();
      out_ready = 1'b1;
      push_n(vecs[v].n, vecs[v].mode, vecs[v].base);
      popped = 0; flushed = 1'b0; c = 0;
      while (obs_data.size() == 0 && c < 200) begin
        drive_fifo();
        #1;
        if (!flushed && vecs[v].flush_at > 0 && fifo_rd_en && popped + 1 == vecs[v].flush_at) begin
          flush = 1'b1; flushed = 1'b1;
        end
        if (!flushed && vecs[v].flush_at < 0 && popped == vecs[v].n && !out_valid) begin
          flush = 1'b1; flushed = 1'b1;
        end
        if (fifo_rd_en) popped++;
        tick();
        c++;
      end
      exp_total++;
      check_word($sformatf("vec%0d", v), 0, 0, vecs[v].exp_count, vecs[v].exp_last);
      chk($sformatf("vec%0d_total", v), LINEW'(total_words), LINEW'(exp_total));
      repeat (3) tick();
      chk($sformatf("vec%0d_one_word", v), LINEW'(obs_data.size()), LINEW'(1));
    end

    // Backpressure: word holds, FIFO untouched, one-cycle latency from last pop.
    src.delete(); clear_obs();
    out_ready = 1'b0;
    push_n(16, 1'b0, 20'h00300);
    push_n(4, 1'b0, 20'h00400);
    popped = 0; c = 0;
    while (!out_valid && c < 100) begin
      drive_fifo();
      #1;
      p16 = fifo_rd_en && (popped == 15);
      if (fifo_rd_en) popped++;
      tick();
      if (p16) chk("bp_latency", LINEW'(out_valid), LINEW'(1));
      c++;
    end
    chk("bp_valid", LINEW'(out_valid), LINEW'(1));
    d0 = out_data;
    repeat (10) begin
      tick();
      chk("bp_stable", out_data, d0);
      chk("bp_valid_hold", LINEW'(out_valid), LINEW'(1));
      chk("bp_no_pop", LINEW'(fifo_rd_en), '0);
    end
    chk("bp_total_held", LINEW'(total_words), LINEW'(exp_total));
    out_ready = 1'b1;
    run_until(1, 5, "bp");
    exp_total++;
    check_word("bp", 0, 0, 16, 1'b0);
    c = 0;
    while (fq.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    flush = 1'b1;
    run_until(2, 20, "bp_tail");
    exp_total++;
    check_word("bp_tail", 1, 16, 4, 1'b1);
    chk("bp_total", LINEW'(total_words), LINEW'(exp_total));

    // Flush on an empty line produces nothing.
    clear_obs();
    flush = 1'b1;
    tick();
    repeat (5) begin
      tick();
      chk("empty_flush_valid", LINEW'(out_valid), '0);
    end
    chk("empty_flush_words", LINEW'(obs_data.size()), '0);

    // Flush during EMIT closes the following word as last.
    src.delete(); clear_obs();
    out_ready = 1'b0;
    push_n(18, 1'b0, 20'h00500);
    c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    flush = 1'b1;
    tick();
    repeat (2) tick();
    out_ready = 1'b1;
    run_until(2, 60, "pend");
    exp_total += 2;
    check_word("pend_w0", 0, 0, 16, 1'b0);
    check_word("pend_w1", 1, 16, 2, 1'b1);
    chk("pend_total", LINEW'(total_words), LINEW'(exp_total));

    // Asynchronous reset with a partial word.
    src.delete(); clear_obs();
    push_n(7, 1'b0, 20'h00600);
    c = 0;
    while (fq.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", LINEW'(out_valid), '0);
    chk("rst_total", LINEW'(total_words), '0);
    chk("rst_data", out_data, '0);
    chk("rst_count", LINEW'(out_count), '0);
    #3 rst = 1'b0;
    exp_total = 0;
    fq.delete(); src.delete(); clear_obs();
    @(posedge clk);
    #1;
    push_n(16, 1'b0, 20'h00700);
    run_until(1, 100, "post_rst");
    exp_total = 1;
    check_word("post_rst", 0, 0, 16, 1'b0);
    chk("post_rst_total", LINEW'(total_words), LINEW'(exp_total));

    // Randomized traffic: words must be the sample stream cut into groups of 16.
    src.delete(); clear_obs();
    n = 16 * 10 + int'($urandom_range(1, 15));
    pushed = 0; c = 0;
    while (c < 6000 && !(pushed == n && fq.size() == 0 && !out_valid)) begin
      if (pushed < n && $urandom_range(0, 3) != 0) begin
        rv = $urandom;
        src.push_back(rv[SW-1:0]);
        fq.push_back(rv[SW-1:0]);
        pushed++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      drive_fifo();
      #1;
      pv = out_valid; pr = out_ready; pd = out_data;
      tick();
      if (pv && !pr) begin
        chk("rand_hold_valid", LINEW'(out_valid), LINEW'(1));
        chk("rand_hold_data", out_data, pd);
      end
      c++;
    end
    if (!(pushed == n && fq.size() == 0)) begin
      n_cmp++; n_bad++;
      $display("FAIL rand_drain: got %0d pushed %0d queued, required %0d pushed 0 queued", pushed, fq.size(), n);
    end
    nfull = n / 16;
    flush = 1'b1;
    out_ready = 1'b1;
    run_until(nfull + 1, 60, "rand_tail");
    chk("rand_words", LINEW'(obs_data.size()), LINEW'(nfull + 1));
    for (int w = 0; w <= nfull; w++) begin
      check_word($sformatf("rand_w%0d", w), w, w * 16, (w < nfull) ? 16 : n % 16, w == nfull);
    end
    exp_total += nfull + 1;
    chk("rand_total", LINEW'(total_words), LINEW'(exp_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
